// File: rtl/mux41_rr_arbiter_if.sv
// Bus between four requesters and the round-robin mux arbiter.
// Handshake: a requester raises req[k] and holds it high as a level for as
// long as it needs the mux. The arbiter answers with gnt[k] one cycle later
// at the earliest. The requester owns the mux while gnt[k]=1. Lowering req[k]
// releases the mux, or withdraws the request if the grant has not yet been
// given. s is the select of the shared mux and equals the owner's index
// whenever busy=1.
interface mux41_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       busy;

  modport master (output req, input gnt, s, busy);
  modport slave  (input req, output gnt, s, busy);
endinterface

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux between four requesters.
// The grant is registered and one-hot, and s drives the mux select directly.
// A tenure lasts at most MAX_HOLD cycles while other requesters are waiting.
// dbg_state reports the FSM state: 0 = IDLE, 1 = GRANT.
module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux41_rr_arbiter_if.slave   bus,
  output logic                dbg_state
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  logic [3:0]    gnt_q;
  logic [1:0]    s_q;
  logic          busy_q;
  logic [1:0]    last;
  logic [HW-1:0] hold_cnt;

  logic [3:0]    owner_oh;
  logic [3:0]    others;
  logic [1:0]    idle_win;
  logic [1:0]    next_win;

  // Circular search starting at from+1. The requester at 'from' is reached
  // only on wrap-around, as the last candidate.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = from;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Winner candidates: from IDLE, search after the last owner. While granted,
  // search after the current owner, among the other requesters only.
  always_comb begin
    owner_oh = 4'(1) << s_q;
    others   = bus.req & ~owner_oh;
    idle_win = pick(bus.req, last);
    next_win = pick(others, s_q);
  end

  // Arbitration FSM with registered grant, select and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= 4'b0000;
      s_q      <= 2'b00;
      busy_q   <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q    <= 4'(1) << idle_win;
            s_q      <= idle_win;
            busy_q   <= 1'b1;
            last     <= idle_win;
            hold_cnt <= HOLD_ONE;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[s_q] || (hold_cnt == HOLD_MAX)) begin
            if (|others) begin
              // Release or preemption with others waiting: hand over without a gap.
              gnt_q    <= 4'(1) << next_win;
              s_q      <= next_win;
              last     <= next_win;
              hold_cnt <= HOLD_ONE;
            end else if (!bus.req[s_q]) begin
              // Released and nobody waiting: go idle; s keeps the last owner.
              gnt_q    <= 4'b0000;
              busy_q   <= 1'b0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
            // Otherwise sole requester at the limit: keep it, counter saturates.
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.busy  = busy_q;
  assign dbg_state = (state == GRANT);

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter (MAX_HOLD=4). Stimulus tasks push the
// expected {gnt,s,busy} after each clock edge. A negedge monitor pops each
// entry and compares it, and it checks the grant invariants every cycle.
// A small mux41 model (i0..i3 = 0,1,0,1) is driven by s.
module tb_mux41_rr_arbiter;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux41_rr_arbiter_if bus();
  logic dbg_state;

  mux41_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // mux41 datapath fed by the arbiter select
  logic [3:0] i_vec = 4'b1010;
  logic       y;
  assign y = i_vec[bus.s];

  int checks = 0;
  int fails  = 0;
  logic [6:0] exp_q[$];
  logic [6:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: apply req, wait for the edge, then push the expected post-edge outputs
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                      input logic eb);
    bus.req = r;
    @(posedge clk);
    exp_q.push_back({eg, es, eb});
    #1;
  endtask

  task automatic step_n(input int n, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] es, input logic eb);
    for (int i = 0; i < n; i++) step(r, eg, es, eb);
  endtask

  // scoreboard monitor and invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",   32'(bus.gnt),  32'(e[6:3]));
      check("s",     32'(bus.s),    32'(e[2:1]));
      check("busy",  32'(bus.busy), 32'(e[0]));
      check("mux_y", 32'(y),        32'(i_vec[e[2:1]]));
    end
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check("busy_vs_gnt", 32'(bus.busy), 32'(|bus.gnt));
    check("dbg_state",   32'(dbg_state), 32'(bus.busy));
    if (bus.busy) check("s_matches_gnt", 32'(bus.gnt[bus.s]), 32'd1);
  end

  initial begin
    bus.req = 4'b0000;
    #1 rst = 1'b1;
    #1;
    check("reset_gnt",  32'(bus.gnt),  32'd0);
    check("reset_s",    32'(bus.s),    32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // all four request: each owner for exactly 4 cycles, order 0,1,2,3,0
    for (int o = 0; o < 5; o++)
      step_n(4, 4'b1111, 4'(1) << (o % 4), 2'(o % 4), 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // single requester: no preemption; after release s keeps 1
    step_n(10, 4'b0010, 4'b0010, 2'd1, 1'b1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);

    // early release by owner 2 hands over to 0 with no gap cycle
    step(4'b0100, 4'b0100, 2'd2, 1'b1);
    step(4'b0101, 4'b0100, 2'd2, 1'b1);
    step(4'b0001, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // fairness wrap: make last=3, then req=1001 alternates 0,3,0 every 4 cycles
    step(4'b1000, 4'b1000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);
    step_n(4, 4'b1001, 4'b0001, 2'd0, 1'b1);
    step_n(4, 4'b1001, 4'b1000, 2'd3, 1'b1);
    step_n(4, 4'b1001, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // asynchronous reset during a tenure, then arbitration restarts from 0
    step(4'b0110, 4'b0010, 2'd1, 1'b1);
    step(4'b0110, 4'b0010, 2'd1, 1'b1);
    #5;
    rst = 1'b1;
    bus.req = 4'b0000;
    #1;
    check("async_rst_gnt",  32'(bus.gnt),  32'd0);
    check("async_rst_s",    32'(bus.s),    32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b1000, 4'b1000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
